// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus outgoing word stream of the dump reader.
// master = the dump reader; slave = register file and downstream consumer.
interface regfile_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;

  modport master (
    output rs_addr, rt_addr, out_valid, out_data, out_index,
    input  rd_data1, rd_data2, out_ready
  );

  modport slave (
    input  rs_addr, rt_addr, out_valid, out_data, out_index,
    output rd_data1, rd_data2, out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Streams the whole register file out in ascending order, fetching an even/odd
// pair per FETCH cycle into two holding buffers and emitting them over valid/ready.
module regfile_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  regfile_dump_reader_if.master        bus,
  output logic                         busy,
  output logic                         done
);
  localparam int PW = ADDR_W - 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SEND_A = 3'd2;
  localparam logic [2:0] S_SEND_B = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [PW-1:0]     pair_q, pair_d;
  logic [DATA_W-1:0] buf_a_q, buf_a_d;
  logic [DATA_W-1:0] buf_b_q, buf_b_d;

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pair_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        buf_a_d = bus.rd_data1;
        buf_b_d = bus.rd_data2;
        state_d = S_SEND_A;
      end
      S_SEND_A: begin
        if (bus.out_ready) state_d = S_SEND_B;
      end
      S_SEND_B: begin
        if (bus.out_ready) begin
          if (&pair_q) begin
            state_d = S_DONE;
          end else begin
            pair_d  = pair_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort outranks every transition above, including a pending transfer.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      pair_d  = pair_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      pair_q  <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
    end
  end

  // All outputs decode from registers only, so they cannot glitch while valid.
  assign bus.rs_addr   = {pair_q, 1'b0};
  assign bus.rt_addr   = {pair_q, 1'b1};
  assign bus.out_valid = (state_q == S_SEND_A) || (state_q == S_SEND_B);
  assign bus.out_data  = (state_q == S_SEND_B) ? buf_b_q : buf_a_q;
  assign bus.out_index = {pair_q, (state_q == S_SEND_B)};
  assign busy          = (state_q == S_FETCH) || (state_q == S_SEND_A) ||
                         (state_q == S_SEND_B);
  assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed vector table plus
// randomized-backpressure dumps checked against an expected transfer list.
module tb_regfile_dump_reader;
  localparam logic [31:0] PRE = 32'hA5A50000;

  logic CLK = 1'b0;
  logic reset, start, abort, busy, done;
  logic [31:0] regs [32];
  logic [31:0] exp_mem [32];
  int checks = 0;
  int errors = 0;

  regfile_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK   (CLK),
    .reset (reset),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 CLK = ~CLK;

  // Combinational register-file read ports.
  assign bus.rd_data1 = regs[bus.rs_addr];
  assign bus.rd_data2 = regs[bus.rt_addr];

  typedef struct {
    logic        start, abort, ready;
    logic        valid;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        busy, done;
    logic [4:0]  rs;
  } vec_t;
  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {14'h0, bus.out_valid, busy, done, bus.out_data, bus.out_index,
               bus.rs_addr, bus.rt_addr},
        {14'h0, 3'b000, 32'h0, 5'h0, 5'h0, 5'h1});
  endtask

  task automatic setv(input int i, input logic s, input logic a, input logic r,
                      input logic v, input logic [4:0] idx, input logic [31:0] d,
                      input logic b, input logic dn, input logic [4:0] rs);
    vecs[i] = '{s, a, r, v, idx, d, b, dn, rs};
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      regs[i]    = PRE + 32'(i);
      exp_mem[i] = PRE + 32'(i);
    end
  endtask

  // Starts a dump and follows it to done or abort; exp_mem holds the expected words.
  task automatic run_dump(input bit rnd, input bit coh, input int abort_idx,
                          input bit poke, output int nx);
    int first_x, last_x;
    bit wrote, pv, pr, rdy;
    logic [4:0]  pidx;
    logic [31:0] pdata;
    nx = 0; first_x = -1; last_x = -1; wrote = 0; pv = 0; pr = 1;
    pidx = '0; pdata = '0;
    start = 1'b1; abort = 1'b0; bus.out_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    for (int cyc = 1; cyc < 1000; cyc++) begin
      if (pv && !pr)
        chk("stall_hold", {26'h0, bus.out_valid, bus.out_index, bus.out_data},
            {26'h0, 1'b1, pidx, pdata});
      if (done) begin
        chk("done_xfers", 64'(nx), 64'd32);
        chk("done_outs", {62'h0, bus.out_valid, busy}, 64'h0);
        if (!rnd) begin
          chk("first_cycle", 64'(first_x), 64'd2);
          chk("last_cycle", 64'(last_x), 64'd48);
          chk("done_cycle", 64'(cyc), 64'd49);
        end
        start = poke;
        @(negedge CLK);
        start = 1'b0;
        chk("idle_after_done", {61'h0, bus.out_valid, busy, done}, 64'h0);
        @(negedge CLK);
        chk("still_idle", {61'h0, bus.out_valid, busy, done}, 64'h0);
        return;
      end
      chk("busy", {63'h0, busy}, 64'h1);
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (coh && bus.out_valid && bus.out_index == 5'd5 && !wrote) begin
        rdy = 1'b0;
        regs[10] = 32'h2;
        regs[4]  = 32'hDEAD0004;
        wrote = 1'b1;
      end
      bus.out_ready = rdy;
      if (abort_idx >= 0 && bus.out_valid && int'(bus.out_index) == abort_idx) begin
        abort = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_idle", {61'h0, bus.out_valid, busy, done}, 64'h0);
        chk("abort_xfers", 64'(nx), 64'(abort_idx));
        for (int j = 0; j < 5; j++) begin
          @(negedge CLK);
          chk("abort_quiet", {61'h0, bus.out_valid, busy, done}, 64'h0);
        end
        return;
      end
      if (poke) start = ($urandom_range(0, 3) == 0);
      if (bus.out_valid && rdy) begin
        chk("xfer", {27'h0, bus.out_index, bus.out_data},
            {27'h0, 5'(nx), (nx < 32) ? exp_mem[nx] : 32'hxxxxxxxx});
        if (nx == 0) first_x = cyc;
        last_x = cyc;
        nx++;
      end
      pv = bus.out_valid; pr = rdy;
      pidx = bus.out_index; pdata = bus.out_data;
      @(negedge CLK);
    end
    checks++; errors++;
    $display("FAIL dump_timeout actual=no_done required=done");
  endtask

  initial begin
    int nx;
    bit found;
    reset = 1'b1; start = 1'b0; abort = 1'b0; bus.out_ready = 1'b0;
    preload();
    repeat (2) @(negedge CLK);
    chk_reset("reset_state");
    reset = 1'b0;
    @(negedge CLK);

    // start sequence, stalls, start-while-busy, abort in SEND_A and in SEND_B
    setv(0,  1, 0, 0, 0, 5'd0, 32'h0,   0, 0, 5'd0);
    setv(1,  0, 0, 0, 0, 5'd0, 32'h0,   1, 0, 5'd0);
    setv(2,  0, 0, 0, 1, 5'd0, PRE + 0, 1, 0, 5'd0);
    setv(3,  0, 0, 1, 1, 5'd0, PRE + 0, 1, 0, 5'd0);
    setv(4,  0, 0, 0, 1, 5'd1, PRE + 1, 1, 0, 5'd0);
    setv(5,  0, 0, 1, 1, 5'd1, PRE + 1, 1, 0, 5'd0);
    setv(6,  1, 0, 0, 0, 5'd0, 32'h0,   1, 0, 5'd2);
    setv(7,  0, 1, 1, 1, 5'd2, PRE + 2, 1, 0, 5'd2);
    setv(8,  0, 0, 0, 0, 5'd0, 32'h0,   0, 0, 5'd2);
    setv(9,  0, 0, 0, 0, 5'd0, 32'h0,   0, 0, 5'd2);
    setv(10, 1, 0, 0, 0, 5'd0, 32'h0,   0, 0, 5'd2);
    setv(11, 0, 0, 0, 0, 5'd0, 32'h0,   1, 0, 5'd0);
    setv(12, 0, 0, 1, 1, 5'd0, PRE + 0, 1, 0, 5'd0);
    setv(13, 0, 1, 1, 1, 5'd1, PRE + 1, 1, 0, 5'd0);
    setv(14, 0, 0, 0, 0, 5'd0, 32'h0,   0, 0, 5'd0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("vec%0d", i),
          {19'h0, bus.out_valid, busy, done, bus.rs_addr,
           bus.out_valid ? bus.out_index : 5'h0, bus.out_valid ? bus.out_data : 32'h0},
          {19'h0, vecs[i].valid, vecs[i].busy, vecs[i].done, vecs[i].rs,
           vecs[i].idx, vecs[i].data});
      start = vecs[i].start; abort = vecs[i].abort; bus.out_ready = vecs[i].ready;
      @(negedge CLK);
    end
    start = 1'b0; abort = 1'b0; bus.out_ready = 1'b0;

    run_dump(1'b0, 1'b0, -1, 1'b0, nx);
    run_dump(1'b1, 1'b0, -1, 1'b1, nx);
    run_dump(1'b1, 1'b0, -1, 1'b0, nx);

    preload();
    regs[10] = 32'h1;
    exp_mem[10] = 32'h2;
    run_dump(1'b1, 1'b1, -1, 1'b0, nx);
    preload();

    run_dump(1'b0, 1'b0, 14, 1'b0, nx);
    run_dump(1'b0, 1'b0, -1, 1'b0, nx);

    // reset mid-dump while stalled
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    bus.out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (bus.out_valid && bus.out_index == 5'd6) begin
        found = 1'b1;
        bus.out_ready = 1'b0;
      end else begin
        @(negedge CLK);
      end
    end
    chk("reach_idx6", {63'h0, found}, 64'h1);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk_reset("reset_mid_dump");
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      chk("idle_after_reset", {61'h0, bus.out_valid, busy, done}, 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
